// File: rtl/inst_loop_pkg.sv
// Shared types and limits for the nested instruction-loop controller.
package inst_loop_pkg;

    localparam int MaxNumLoops   = 8;
    localparam int DefAddrWidth  = 32;
    localparam int DefCountWidth = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } loop_state_e;

    typedef struct packed {
        logic [DefAddrWidth-1:0]  jump_addr;
        logic [DefAddrWidth-1:0]  end_addr;
        logic [DefCountWidth-1:0] count;
    } loop_cfg_t;

endpackage

// File: rtl/inst_loop_level_cnt.sv
// Iteration counter for one loop level; a programmed count of 0 behaves as a single pass.
module inst_loop_level_cnt #(
    parameter int CountWidth = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  adv_i,
    input  logic                  hit_i,
    input  logic                  inc_i,
    input  logic                  wrap_i,
    input  logic [CountWidth-1:0] count_i,
    output logic [CountWidth-1:0] cnt_o,
    output logic                  last_o
);

    logic [CountWidth-1:0] cnt_r;

    function automatic logic [CountWidth-1:0] final_index(input logic [CountWidth-1:0] count);
        logic [CountWidth-1:0] idx;
        if (count == {CountWidth{1'b0}}) begin
            idx = {CountWidth{1'b0}};
        end else begin
            idx = count - CountWidth'(1);
        end
        return idx;
    endfunction

    assign last_o = (cnt_r == final_index(count_i));
    assign cnt_o  = cnt_r;

    // Count up on a jump from this level, wrap to zero when its final pass completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= {CountWidth{1'b0}};
        end else if (clr_i) begin
            cnt_r <= {CountWidth{1'b0}};
        end else if (adv_i && hit_i && inc_i && !last_o) begin
            cnt_r <= cnt_r + CountWidth'(1);
        end else if (adv_i && hit_i && last_o && wrap_i) begin
            cnt_r <= {CountWidth{1'b0}};
        end
    end

endmodule

// File: rtl/inst_loop_nest_ctrl_chk.sv
// Protocol checks for inst_loop_nest_ctrl: the loop mode must stay stable while running.
module inst_loop_nest_ctrl_chk
    import inst_loop_pkg::*;
#(
    parameter int NumLoops     = 4,
    parameter int LoopNumWidth = 3
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    input logic                    busy_i,
    input logic [LoopNumWidth-1:0] mode_i
);

    mode_stable_in_run: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (busy_i && $past(busy_i)) |-> $stable(mode_i));

    depth_in_range: assert property (@(posedge clk_i)
        (NumLoops >= 1) && (NumLoops <= MaxNumLoops));

endmodule

// File: rtl/inst_loop_nest_ctrl.sv
// N-level nested loop controller: matches the PC against per-level end addresses and drives the PC mux.
// Optional performance counters are built when INST_LOOP_PERF_CNT_EN is defined.
module inst_loop_nest_ctrl
    import inst_loop_pkg::*;
#(
    parameter int  InstMemAddrWidth   = 32,
    parameter int  InstLoopCountWidth = 10,
    parameter int  NumLoops           = 4,
    localparam int LoopNumWidth       = $clog2(NumLoops + 1)
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         clr_i,
    input  logic                                         en_i,
    input  logic                                         stall_i,
    input  logic                                         dbg_en_i,
    input  logic [InstMemAddrWidth-1:0]                  inst_pc_i,
    input  logic [LoopNumWidth-1:0]                      inst_loop_mode_i,
    input  logic [NumLoops-1:0][InstMemAddrWidth-1:0]    inst_loop_jump_addr_i,
    input  logic [NumLoops-1:0][InstMemAddrWidth-1:0]    inst_loop_end_addr_i,
    input  logic [NumLoops-1:0][InstLoopCountWidth-1:0]  inst_loop_count_i,
    output logic                                         inst_jump_o,
    output logic [InstMemAddrWidth-1:0]                  inst_jump_addr_o,
    output logic                                         inst_loop_done_o,
    output logic                                         inst_loop_busy_o,
    output logic [NumLoops-1:0][InstLoopCountWidth-1:0]  inst_loop_iter_o
`ifdef INST_LOOP_PERF_CNT_EN
    ,
    output logic [31:0]                                  inst_loop_jump_cnt_o,
    output logic [31:0]                                  inst_loop_cycle_cnt_o
`endif
);

    loop_state_e                 state_r, state_s;
    logic                        run_s, adv_s, clear_s, any_sel_s, done_s;
    logic [NumLoops-1:0]         hit_s, last_s, outer_s, sel_s, wrap_s;
    logic [InstMemAddrWidth-1:0] sel_addr_s;

    assign run_s   = (state_r == RUN);
    assign adv_s   = en_i & ~stall_i & ~dbg_en_i & run_s;
    assign clear_s = clr_i | ~en_i;

    for (genvar k = 0; k < NumLoops; k++) begin : g_level
        assign hit_s[k]   = (LoopNumWidth'(k) < inst_loop_mode_i) &&
                            (inst_pc_i == inst_loop_end_addr_i[k]);
        assign outer_s[k] = (inst_loop_mode_i == LoopNumWidth'(k + 1));

        inst_loop_level_cnt #(
            .CountWidth (InstLoopCountWidth)
        ) u_cnt (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clr_i   (clear_s),
            .adv_i   (adv_s),
            .hit_i   (hit_s[k]),
            .inc_i   (sel_s[k]),
            .wrap_i  (wrap_s[k]),
            .count_i (inst_loop_count_i[k]),
            .cnt_o   (inst_loop_iter_o[k]),
            .last_o  (last_s[k])
        );
    end

    // Innermost level still iterating wins; levels below it (and all levels if none wins) may wrap.
    always_comb begin
        sel_s      = {NumLoops{1'b0}};
        wrap_s     = {NumLoops{1'b0}};
        any_sel_s  = 1'b0;
        sel_addr_s = {InstMemAddrWidth{1'b0}};
        for (int k = 0; k < NumLoops; k++) begin
            if (!any_sel_s) begin
                wrap_s[k] = 1'b1;
                if (hit_s[k] && !last_s[k]) begin
                    sel_s[k]   = 1'b1;
                    any_sel_s  = 1'b1;
                    sel_addr_s = inst_loop_jump_addr_i[k];
                end else begin
                    sel_s[k] = 1'b0;
                end
            end else begin
                wrap_s[k] = 1'b0;
            end
        end
    end

    assign done_s = adv_s & ~any_sel_s & (|(outer_s & hit_s & last_s));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state: clear and disable override a stall, which in turn freezes the machine.
    always_comb begin
        state_s = state_r;
        if (clr_i || !en_i) begin
            state_s = IDLE;
        end else if (stall_i || dbg_en_i) begin
            state_s = state_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (inst_loop_mode_i != {LoopNumWidth{1'b0}}) begin
                        state_s = RUN;
                    end else begin
                        state_s = IDLE;
                    end
                end
                RUN: begin
                    if (done_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end
                DONE:    state_s = DONE;
                default: state_s = IDLE;
            endcase
        end
    end

    assign inst_jump_o      = run_s & any_sel_s;
    assign inst_jump_addr_o = run_s ? sel_addr_s : {InstMemAddrWidth{1'b0}};
    assign inst_loop_done_o = done_s;
    assign inst_loop_busy_o = run_s;

`ifdef INST_LOOP_PERF_CNT_EN
    logic [31:0] jump_cnt_r, cycle_cnt_r;

    // Saturating counts of taken jumps and of cycles spent running.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            jump_cnt_r  <= 32'd0;
            cycle_cnt_r <= 32'd0;
        end else if (clr_i) begin
            jump_cnt_r  <= 32'd0;
            cycle_cnt_r <= 32'd0;
        end else begin
            if (adv_s && any_sel_s && (jump_cnt_r != {32{1'b1}})) begin
                jump_cnt_r <= jump_cnt_r + 32'd1;
            end
            if (run_s && (cycle_cnt_r != {32{1'b1}})) begin
                cycle_cnt_r <= cycle_cnt_r + 32'd1;
            end
        end
    end

    assign inst_loop_jump_cnt_o  = jump_cnt_r;
    assign inst_loop_cycle_cnt_o = cycle_cnt_r;
`endif

endmodule

// File: tb/tb_inst_loop_nest_ctrl.sv
// Self-checking bench for inst_loop_nest_ctrl: vector table, directed corner sequences, random vs model.
module tb_inst_loop_nest_ctrl;
    import inst_loop_pkg::*;

    localparam int AW = 32;
    localparam int CW = 10;
    localparam int NL = 4;
    localparam int MW = $clog2(NL + 1);

    logic                   clk, rst_n, clr, en, stall, dbg;
    logic [AW-1:0]          pc;
    logic [MW-1:0]          mode;
    logic [NL-1:0][AW-1:0]  jump_addr, end_addr;
    logic [NL-1:0][CW-1:0]  count;
    logic                   jump, done, busy;
    logic [AW-1:0]          jaddr;
    logic [NL-1:0][CW-1:0]  iter;
`ifdef INST_LOOP_PERF_CNT_EN
    logic [31:0]            jump_cnt, cycle_cnt;
`endif

    int errors = 0;
    int checks = 0;

    inst_loop_nest_ctrl #(
        .InstMemAddrWidth   (AW),
        .InstLoopCountWidth (CW),
        .NumLoops           (NL)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .clr_i                 (clr),
        .en_i                  (en),
        .stall_i               (stall),
        .dbg_en_i              (dbg),
        .inst_pc_i             (pc),
        .inst_loop_mode_i      (mode),
        .inst_loop_jump_addr_i (jump_addr),
        .inst_loop_end_addr_i  (end_addr),
        .inst_loop_count_i     (count),
        .inst_jump_o           (jump),
        .inst_jump_addr_o      (jaddr),
        .inst_loop_done_o      (done),
        .inst_loop_busy_o      (busy),
        .inst_loop_iter_o      (iter)
`ifdef INST_LOOP_PERF_CNT_EN
        ,
        .inst_loop_jump_cnt_o  (jump_cnt),
        .inst_loop_cycle_cnt_o (cycle_cnt)
`endif
    );

    inst_loop_nest_ctrl_chk #(.NumLoops(NL), .LoopNumWidth(MW)) u_chk (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .busy_i (busy),
        .mode_i (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required self-termination");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_level(input int k, input loop_cfg_t c);
        jump_addr[k] = c.jump_addr;
        end_addr[k]  = c.end_addr;
        count[k]     = c.count;
    endtask

    task automatic clear_cfg();
        for (int k = 0; k < NL; k++)
            set_level(k, '{jump_addr: 32'h0, end_addr: 32'hFFFF_FFF0, count: 10'd0});
    endtask

    // Reference model: loop state as plain integers, updated from the loop rules once per cycle.
    int m_state;             // 0 idle, 1 running, 2 finished
    int m_cnt [NL];

    function automatic int bnd(input int k);
        return (count[k] == 10'd0) ? 1 : int'(count[k]);
    endfunction

    task automatic model_check();
        int sel, m;
        bit run, adv, d;
        logic [AW-1:0] ea;
        logic [NL-1:0][CW-1:0] ei;
        m   = int'(mode);
        run = (m_state == 1);
        sel = -1;
        for (int k = 0; k < NL; k++)
            if (sel < 0 && k < m && pc == end_addr[k] && m_cnt[k] != bnd(k) - 1) sel = k;
        adv = en && !stall && !dbg && run;
        d   = 1'b0;
        if (adv && sel < 0 && m >= 1 && m <= NL)
            d = (pc == end_addr[m-1]) && (m_cnt[m-1] == bnd(m-1) - 1);
        ea = '0;
        if (run && sel >= 0) ea = jump_addr[sel];
        for (int k = 0; k < NL; k++) ei[k] = CW'(m_cnt[k]);
        chk("rnd_jump", jump, run && sel >= 0);
        chk("rnd_addr", jaddr, ea);
        chk("rnd_done", done, d);
        chk("rnd_busy", busy, run);
        chk("rnd_iter", iter, ei);
        if (clr || !en) begin
            m_state = 0;
            for (int k = 0; k < NL; k++) m_cnt[k] = 0;
        end else if (stall || dbg) begin
            m_state = m_state;
        end else if (m_state == 0) begin
            if (m != 0) m_state = 1;
        end else if (m_state == 1) begin
            for (int j = 0; j < NL; j++)
                if (j < m && pc == end_addr[j] && m_cnt[j] == bnd(j) - 1 && (sel < 0 || j < sel))
                    m_cnt[j] = 0;
            if (sel >= 0) m_cnt[sel]++;
            if (d) m_state = 2;
        end
    endtask

    typedef struct {
        logic          en;
        logic          stall;
        logic [AW-1:0] pc;
        logic          jump;
        logic [AW-1:0] addr;
        logic          done;
        logic          busy;
        logic [CW-1:0] iter0;
    } vec_t;

    vec_t          tbl [11];
    logic [AW-1:0] nxt;
    int            l0j, l1j, l0h, seen, fin, pcyc;
    logic [AW-1:0] dpc;
    logic          sh_jump [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [AW-1:0] sh_addr [4] = '{32'h10, 32'h18, 32'h10, 32'h00};
    logic          sh_done [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [CW-1:0] sh_c0   [4] = '{10'd1, 10'd0, 10'd1, 10'd0};
    logic [CW-1:0] sh_c1   [4] = '{10'd0, 10'd1, 10'd1, 10'd0};

    initial begin
        rst_n = 1'b1; clr = 1'b0; en = 1'b0; stall = 1'b0; dbg = 1'b0;
        pc = '0; mode = '0;
        clear_cfg();
        #1 rst_n = 1'b0;
        #11;
        chk("reset_jump", jump, 1'b0);
        chk("reset_addr", jaddr, 32'h0);
        chk("reset_done", done, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_iter", iter, '0);
        rst_n = 1'b1;
        tick();

        // Single level, three passes, with a stall on the second hit.
        tbl[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b0, 10'd0};
        tbl[1]  = '{1'b1, 1'b0, 32'h04, 1'b0, 32'h00, 1'b0, 1'b1, 10'd0};
        tbl[2]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h04, 1'b0, 1'b1, 10'd0};
        tbl[3]  = '{1'b1, 1'b0, 32'h04, 1'b0, 32'h00, 1'b0, 1'b1, 10'd1};
        tbl[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04, 1'b0, 1'b1, 10'd1};
        tbl[5]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h04, 1'b0, 1'b1, 10'd1};
        tbl[6]  = '{1'b1, 1'b0, 32'h08, 1'b0, 32'h00, 1'b0, 1'b1, 10'd2};
        tbl[7]  = '{1'b1, 1'b0, 32'h10, 1'b0, 32'h00, 1'b1, 1'b1, 10'd2};
        tbl[8]  = '{1'b1, 1'b0, 32'h10, 1'b0, 32'h00, 1'b0, 1'b0, 10'd0};
        tbl[9]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b0, 10'd0};
        tbl[10] = '{1'b0, 1'b0, 32'h10, 1'b0, 32'h00, 1'b0, 1'b0, 10'd0};
        set_level(0, '{jump_addr: 32'h04, end_addr: 32'h10, count: 10'd3});
        mode = 3'd1;
        for (int i = 0; i < 11; i++) begin
            en = tbl[i].en; stall = tbl[i].stall; pc = tbl[i].pc;
            @(negedge clk);
            chk("tbl_jump", jump, tbl[i].jump);
            chk("tbl_addr", jaddr, tbl[i].addr);
            chk("tbl_done", done, tbl[i].done);
            chk("tbl_busy", busy, tbl[i].busy);
            chk("tbl_iter0", iter[0], tbl[i].iter0);
            tick();
        end

        // Two nested levels driven by a PC that follows the jump output.
        clear_cfg();
        set_level(0, '{jump_addr: 32'h02, end_addr: 32'h08, count: 10'd2});
        set_level(1, '{jump_addr: 32'h00, end_addr: 32'h0C, count: 10'd3});
        mode = 3'd2; en = 1'b1; pc = 32'h0;
        l0j = 0; l1j = 0; l0h = 0; seen = 0; fin = 0; dpc = '0;
        for (int cyc = 0; cyc < 200 && seen == 0; cyc++) begin
            @(negedge clk);
            if (fin != 0) begin
                chk("nest_iter0_wrap", iter[0], 10'd0);
                fin = 0;
            end
            if (pc == 32'h08 && busy) begin
                l0h++;
                if (jump) l0j++;
                else fin = 1;
            end
            if (pc == 32'h0C && jump) l1j++;
            if (done) begin seen = 1; dpc = pc; end
            nxt = jump ? jaddr : pc + 32'd2;
            tick();
            pc = nxt;
        end
        chk("nest_done_seen", seen, 1);
        chk("nest_l0_jumps", l0j, 3);
        chk("nest_l1_jumps", l1j, 2);
        chk("nest_l0_hits", l0h, 6);
        chk("nest_done_pc", dpc, 32'h0C);
        en = 1'b0; tick();

        // Two levels sharing one end address.
        clear_cfg();
        set_level(0, '{jump_addr: 32'h10, end_addr: 32'h20, count: 10'd2});
        set_level(1, '{jump_addr: 32'h18, end_addr: 32'h20, count: 10'd2});
        mode = 3'd2; en = 1'b1; pc = 32'h0;
        tick();
        for (int h = 0; h < 4; h++) begin
            pc = 32'h20;
            @(negedge clk);
            chk("shared_jump", jump, sh_jump[h]);
            chk("shared_addr", jaddr, sh_addr[h]);
            chk("shared_done", done, sh_done[h]);
            tick();
            pc = 32'h24;
            @(negedge clk);
            chk("shared_cnt0", iter[0], sh_c0[h]);
            chk("shared_cnt1", iter[1], sh_c1[h]);
            tick();
        end
        en = 1'b0; tick();

        // A count of zero acts as a single pass; a stall across the hit holds everything.
        clear_cfg();
        set_level(0, '{jump_addr: 32'h40, end_addr: 32'h30, count: 10'd0});
        mode = 3'd1; en = 1'b1; pc = 32'h0;
        tick();
        pc = 32'h30; stall = 1'b1;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            chk("zero_stall_jump", jump, 1'b0);
            chk("zero_stall_done", done, 1'b0);
            chk("zero_stall_busy", busy, 1'b1);
            chk("zero_stall_iter", iter[0], 10'd0);
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("zero_jump", jump, 1'b0);
        chk("zero_done", done, 1'b1);
        tick();
        @(negedge clk);
        chk("zero_after_busy", busy, 1'b0);
        en = 1'b0; tick();

`ifdef INST_LOOP_PERF_CNT_EN
        clear_cfg();
        set_level(0, '{jump_addr: 32'h0C, end_addr: 32'h10, count: 10'd6});
        mode = 3'd1; clr = 1'b1; tick(); clr = 1'b0;
        chk("perf_clr_jump", jump_cnt, 32'd0);
        chk("perf_clr_cycle", cycle_cnt, 32'd0);
        en = 1'b1; pc = 32'h0C; pcyc = 0; seen = 0;
        for (int cyc = 0; cyc < 100 && seen == 0; cyc++) begin
            @(negedge clk);
            if (busy) pcyc++;
            if (done) seen = 1;
            nxt = jump ? jaddr : ((pc == 32'h0C) ? 32'h10 : 32'h0C);
            tick();
            pc = nxt;
        end
        @(negedge clk);
        chk("perf_jump_cnt", jump_cnt, 32'd5);
        chk("perf_cycle_cnt", cycle_cnt, pcyc);
        en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        chk("perf_zero_jump", jump_cnt, 32'd0);
        chk("perf_zero_cycle", cycle_cnt, 32'd0);
`endif

        // Asynchronous reset in the middle of a run.
        clear_cfg();
        set_level(0, '{jump_addr: 32'h04, end_addr: 32'h10, count: 10'd5});
        mode = 3'd1; en = 1'b1; pc = 32'h0;
        tick();
        pc = 32'h10; tick();
        pc = 32'h04; tick();
        pc = 32'h10; tick();
        @(negedge clk);
        chk("midrst_pre_iter", iter[0], 10'd2);
        chk("midrst_pre_jump", jump, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_jump", jump, 1'b0);
        chk("midrst_addr", jaddr, 32'h0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_iter", iter, '0);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_idle_busy", busy, 1'b0);
        chk("midrst_idle_iter", iter, '0);
        en = 1'b1;
        #1;
        chk("midrst_en_busy", busy, 1'b0);
        chk("midrst_en_jump", jump, 1'b0);
        @(negedge clk);
        chk("midrst_resume_busy", busy, 1'b1);
        chk("midrst_resume_iter", iter[0], 10'd0);
        chk("midrst_resume_jump", jump, 1'b1);
        chk("midrst_resume_addr", jaddr, 32'h04);
        en = 1'b0; tick();

        // Randomised episodes checked against the reference model.
        rst_n = 1'b0; #2 rst_n = 1'b1;
        m_state = 0;
        for (int k = 0; k < NL; k++) m_cnt[k] = 0;
        tick();
        for (int ep = 0; ep < 20; ep++) begin
            en = 1'b0; clr = 1'b0; stall = 1'b0; dbg = 1'b0;
            @(negedge clk);
            model_check();
            tick();
            mode = MW'($urandom_range(0, NL));
            for (int k = 0; k < NL; k++)
                set_level(k, '{jump_addr: AW'(4 * $urandom_range(0, 8)),
                               end_addr:  AW'(4 * $urandom_range(0, 8)),
                               count:     CW'($urandom_range(0, 3))});
            for (int c = 0; c < 150; c++) begin
                en    = ($urandom_range(0, 39) != 0);
                stall = ($urandom_range(0, 7) == 0);
                dbg   = ($urandom_range(0, 15) == 0);
                clr   = ($urandom_range(0, 49) == 0);
                pc    = AW'(4 * $urandom_range(0, 8));
                @(negedge clk);
                model_check();
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
